// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the time-division segment scan multiplexer.
// Holds the scan state encoding, the one-hot helper and the slot-counter sizing rule.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    BLANK  = 2'd2,
    MANUAL = 2'd3
  } scan_state_e;

  localparam int unsigned MAX_CH       = 64;
  // Smallest slot length the counter is sized for, so it is never zero bits wide.
  localparam int unsigned MIN_SLOT_CYC = 2;

  function automatic int unsigned ctr_width(input int unsigned show_cyc,
                                            input int unsigned blank_cyc);
    int unsigned m;
    m = MIN_SLOT_CYC;
    if (show_cyc > m) m = show_cyc;
    if (blank_cyc > m) m = blank_cyc;
    return $clog2(m);
  endfunction

  function automatic logic [MAX_CH-1:0] onehot(input int unsigned idx,
                                               input int unsigned n);
    logic [MAX_CH-1:0] v;
    v = '0;
    if (idx < n) v = MAX_CH'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/seg_scan_next_ch.sv
// Next-enabled-channel search: first set mask bit strictly after cur, wrapping.
// wrapped flags a new index <= cur; none flags an all-zero mask.
module seg_scan_next_ch
  import seg_scan_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [SEL_W-1:0]  cur,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [SEL_W-1:0]  nxt,
  output logic              wrapped,
  output logic              none
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    nxt     = '0;
    wrapped = 1'b0;
    none    = 1'b1;
    idx     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = SEL_W'((32'(cur) + 32'(i)) % NUM_CH);
      if (none && ch_mask[idx]) begin
        nxt     = idx;
        wrapped = (idx <= cur);
        none    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Registered N-channel multiplexer with automatic time-division scanning,
// blanking gaps between slots, per-channel skip mask and a manual select mode.
//
// state  | meaning
// IDLE   | outputs blank, waiting for en (and a non-empty mask in auto mode)
// SHOW   | driving channel cur for SHOW_CYC cycles
// BLANK  | all-zero gap of BLANK_CYC cycles before advancing
// MANUAL | channel chosen directly by sel_in
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int WIDTH     = 7,
  parameter int NUM_CH    = 8,
  parameter int SEL_W     = $clog2(NUM_CH),
  parameter int SHOW_CYC  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]        out,
  output logic [NUM_CH-1:0]       ch_oh,
  output logic [SEL_W-1:0]        sel_out,
  output logic                    frame_done
);

  localparam int CTR_W = int'(ctr_width(SHOW_CYC, BLANK_CYC));
  localparam logic [CTR_W-1:0] SHOW_LOAD  = CTR_W'(SHOW_CYC - 1);
  localparam logic [CTR_W-1:0] BLANK_LOAD = CTR_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  scan_state_e       state_q, state_d;
  logic [SEL_W-1:0]  cur_q, cur_d;
  logic [CTR_W-1:0]  cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [NUM_CH-1:0] ch_oh_q, ch_oh_d;
  logic [SEL_W-1:0]  sel_out_q, sel_out_d;
  logic              frame_done_q, frame_done_d;

  logic [SEL_W-1:0]  search_from;
  logic [SEL_W-1:0]  nxt;
  logic              wrapped;
  logic              none;
  logic              advance;
  logic [MAX_CH-1:0] oh_full;
  logic [WIDTH-1:0]  ch_data [NUM_CH];

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) ch_data[k] = data_in[k*WIDTH +: WIDTH];
  end

  // From IDLE, searching after the last index yields the lowest enabled channel.
  assign search_from = (state_q == IDLE) ? SEL_W'(NUM_CH - 1) : cur_q;

  seg_scan_next_ch #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_next_ch (
    .cur     (search_from),
    .ch_mask (ch_mask),
    .nxt     (nxt),
    .wrapped (wrapped),
    .none    (none)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      cnt_q        <= '0;
      wrap_q       <= 1'b0;
      out_q        <= '0;
      ch_oh_q      <= '0;
      sel_out_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      cnt_q        <= cnt_d;
      wrap_q       <= wrap_d;
      out_q        <= out_d;
      ch_oh_q      <= ch_oh_d;
      sel_out_q    <= sel_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          if (mode) begin
            state_d = MANUAL;
          end else if (!none) begin
            state_d = SHOW;
            cur_d   = nxt;
            cnt_d   = SHOW_LOAD;
            wrap_d  = 1'b0;
          end
        end
      end
      SHOW: begin
        wrap_d = 1'b0;
        if (!en) begin
          state_d = IDLE;
        end else if (mode) begin
          state_d = MANUAL;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CTR_W'(1);
        end else if (BLANK_CYC > 0) begin
          state_d = BLANK;
          cnt_d   = BLANK_LOAD;
        end else begin
          advance = 1'b1;
        end
      end
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
        end else if (mode) begin
          state_d = MANUAL;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CTR_W'(1);
        end else begin
          advance = 1'b1;
        end
      end
      MANUAL: begin
        if (!en || !mode) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (none) begin
        state_d = IDLE;
      end else begin
        state_d = SHOW;
        cur_d   = nxt;
        cnt_d   = SHOW_LOAD;
        wrap_d  = wrapped;
      end
    end
  end

  // Outputs are gated by the live en/mode so a disable or mode flip blanks on the next cycle.
  always_comb begin
    out_d        = '0;
    ch_oh_d      = '0;
    sel_out_d    = sel_out_q;
    frame_done_d = 1'b0;
    oh_full      = '0;
    if (en) begin
      if (state_q == SHOW && !mode) begin
        oh_full      = onehot(32'(cur_q), NUM_CH);
        out_d        = ch_data[cur_q];
        ch_oh_d      = oh_full[NUM_CH-1:0];
        sel_out_d    = cur_q;
        frame_done_d = wrap_q;
      end else if (state_q == MANUAL && mode) begin
        sel_out_d = sel_in;
        if ((32'(sel_in) < NUM_CH) && ch_mask[sel_in]) begin
          oh_full = onehot(32'(sel_in), NUM_CH);
          out_d   = ch_data[sel_in];
          ch_oh_d = oh_full[NUM_CH-1:0];
        end
      end
    end
  end

  assign out        = out_q;
  assign ch_oh      = ch_oh_q;
  assign sel_out    = sel_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised bench for seg_scan_mux: a gap build and a no-gap build run side by side
// against a slot-position reference model, plus directed scenario and frame-period checks.
module tb_seg_scan_mux;

  localparam int WIDTH  = 7;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int SHOW   = 4;
  localparam int BLK0   = 2;
  localparam int BLK1   = 0;
  localparam logic [27:0] DATA0 = {7'h4F, 7'h5B, 7'h06, 7'h3F};

  logic        clk = 1'b0;
  logic        reset, en, mode;
  logic [1:0]  sel_in;
  logic [3:0]  ch_mask;
  logic [27:0] data_in;

  logic [6:0] out0, out1;
  logic [3:0] oh0, oh1;
  logic [1:0] so0, so1;
  logic       fd0, fd1;

  always #5 clk = ~clk;

  seg_scan_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W),
                 .SHOW_CYC(SHOW), .BLANK_CYC(BLK0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel_in(sel_in),
    .ch_mask(ch_mask), .data_in(data_in), .out(out0), .ch_oh(oh0),
    .sel_out(so0), .frame_done(fd0));

  seg_scan_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W),
                 .SHOW_CYC(SHOW), .BLANK_CYC(BLK1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel_in(sel_in),
    .ch_mask(ch_mask), .data_in(data_in), .out(out1), .ch_oh(oh1),
    .sel_out(so1), .frame_done(fd1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: where each build is within its slot, kept as a position count.
  bit         m_scan [2];
  bit         m_man  [2];
  int         m_ch   [2];
  int         m_pos  [2];
  bit         m_wrap [2];
  logic [6:0] e_out  [2];
  logic [3:0] e_oh   [2];
  logic [1:0] e_sel  [2];
  logic       e_fd   [2];

  function automatic int slot_len(input int d);
    return SHOW + ((d == 0) ? BLK0 : BLK1);
  endfunction

  function automatic int lowest_on(input logic [3:0] m);
    for (int k = 0; k < NUM_CH; k++) if (m[k]) return k;
    return -1;
  endfunction

  function automatic int next_after(input int from, input logic [3:0] m);
    int c;
    for (int s = 1; s <= NUM_CH; s++) begin
      c = (from + s) % NUM_CH;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input int d);
    int nx;
    int s;
    e_out[d] = '0;
    e_oh[d]  = '0;
    e_fd[d]  = 1'b0;
    if (reset) begin
      m_scan[d] = 0; m_man[d] = 0; m_ch[d] = 0; m_pos[d] = 0; m_wrap[d] = 0;
      e_sel[d] = '0;
      return;
    end
    if (en) begin
      if (m_scan[d] && !mode && m_pos[d] < SHOW) begin
        e_out[d] = data_in[m_ch[d]*WIDTH +: WIDTH];
        e_oh[d]  = 4'(1 << m_ch[d]);
        e_sel[d] = 2'(m_ch[d]);
        e_fd[d]  = m_wrap[d] && (m_pos[d] == 0);
      end else if (m_man[d] && mode) begin
        s = int'(sel_in);
        e_sel[d] = sel_in;
        if (ch_mask[s]) begin
          e_out[d] = data_in[s*WIDTH +: WIDTH];
          e_oh[d]  = 4'(1 << s);
        end
      end
    end
    if (!en) begin
      m_scan[d] = 0;
      m_man[d]  = 0;
    end else if (m_man[d]) begin
      if (!mode) m_man[d] = 0;
    end else if (m_scan[d]) begin
      if (mode) begin
        m_scan[d] = 0;
        m_man[d]  = 1;
      end else begin
        m_pos[d]++;
        if (m_pos[d] == slot_len(d)) begin
          nx = next_after(m_ch[d], ch_mask);
          if (nx < 0) begin
            m_scan[d] = 0;
          end else begin
            m_wrap[d] = (nx <= m_ch[d]);
            m_ch[d]   = nx;
            m_pos[d]  = 0;
          end
        end
      end
    end else begin
      if (mode) begin
        m_man[d] = 1;
      end else if (ch_mask != 0) begin
        m_scan[d] = 1;
        m_ch[d]   = lowest_on(ch_mask);
        m_pos[d]  = 0;
        m_wrap[d] = 0;
      end
    end
  endtask

  int cyc = 0;
  bit per_on = 0;
  int last_fd [2];
  int exp_per [2];

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_eq("out_g",   32'(out0), 32'(e_out[0]));
    check_eq("oh_g",    32'(oh0),  32'(e_oh[0]));
    check_eq("sel_g",   32'(so0),  32'(e_sel[0]));
    check_eq("fd_g",    32'(fd0),  32'(e_fd[0]));
    check_eq("out_ng",  32'(out1), 32'(e_out[1]));
    check_eq("oh_ng",   32'(oh1),  32'(e_oh[1]));
    check_eq("sel_ng",  32'(so1),  32'(e_sel[1]));
    check_eq("fd_ng",   32'(fd1),  32'(e_fd[1]));
    if (per_on) begin
      if (fd0) begin
        if (last_fd[0] >= 0) check_eq("period_g", 32'(cyc - last_fd[0]), 32'(exp_per[0]));
        last_fd[0] = cyc;
      end
      if (fd1) begin
        if (last_fd[1] >= 0) check_eq("period_ng", 32'(cyc - last_fd[1]), 32'(exp_per[1]));
        last_fd[1] = cyc;
      end
    end
    cyc++;
  endtask

  initial begin
    bit saw;
    int r;
    int guard;
    reset = 1'b1; en = 1'b0; mode = 1'b0; sel_in = '0;
    ch_mask = 4'b1111; data_in = DATA0;
    last_fd = '{-1, -1};
    exp_per = '{0, 0};
    repeat (3) tick();
    check_eq("rst_out",  32'(out0), 32'h0);
    check_eq("rst_oh",   32'(oh0),  32'h0);
    check_eq("rst_sel",  32'(so0),  32'h0);
    check_eq("rst_fd",   32'(fd0),  32'h0);

    // Full mask: k=4 channels, frame = 4*(4+2) and 4*(4+0).
    reset = 1'b0; en = 1'b1;
    tick();
    tick();
    check_eq("first_slot_out", 32'(out0), 32'h3F);
    check_eq("first_slot_oh",  32'(oh0),  32'h1);
    last_fd = '{-1, -1};
    exp_per = '{24, 16};
    per_on  = 1;
    repeat (80) tick();
    per_on = 0;

    // Alternate channels 1 and 3.
    ch_mask = 4'b1010;
    repeat (20) tick();
    last_fd = '{-1, -1};
    exp_per = '{12, 8};
    per_on  = 1;
    repeat (40) tick();
    per_on = 0;

    // Empty mask drains to IDLE, then a single channel restarts the scan.
    ch_mask = 4'b0000;
    repeat (20) tick();
    check_eq("mask0_out", 32'(out0), 32'h0);
    check_eq("mask0_oh",  32'(oh0),  32'h0);
    ch_mask = 4'b0100;
    saw = 0;
    repeat (12) begin
      tick();
      if (out0 == 7'h5B && oh0 == 4'b0100) saw = 1;
    end
    check_eq("ch2_shown", 32'(saw), 32'h1);

    // Manual select.
    mode = 1'b1; sel_in = 2'd2; ch_mask = 4'b1111;
    tick();
    tick();
    check_eq("man_sel2", 32'(out0), 32'h5B);
    ch_mask = 4'b1011;
    tick();
    check_eq("man_masked", 32'(out0), 32'h0);
    sel_in = 2'd3; ch_mask = 4'b1111;
    tick();
    check_eq("man_sel3_out", 32'(out0), 32'h4F);
    check_eq("man_sel3_oh",  32'(oh0),  32'h8);
    check_eq("man_sel3_sel", 32'(so0),  32'h3);

    // Back to auto, then drop en mid-SHOW.
    mode = 1'b0;
    repeat (3) tick();
    check_eq("auto_restart", 32'(out0), 32'h3F);
    en = 1'b0;
    tick();
    check_eq("en_drop_out", 32'(out0), 32'h0);
    check_eq("en_drop_oh",  32'(oh0),  32'h0);

    // Reset while the gap build is in its blanking gap.
    en = 1'b1;
    guard = 0;
    while (!(m_scan[0] && m_pos[0] >= SHOW) && guard < 40) begin
      tick();
      guard++;
    end
    check_eq("reach_blank", 32'(guard < 40), 32'h1);
    reset = 1'b1;
    tick();
    check_eq("rst_blank_out", 32'(out0), 32'h0);
    check_eq("rst_blank_sel", 32'(so0),  32'h0);
    reset = 1'b0;
    tick();
    tick();
    check_eq("rst_restart_ch0", 32'(out0), 32'h3F);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      data_in = 28'($urandom);
      sel_in  = 2'($urandom);
      r = int'($urandom_range(0, 999));
      reset = 1'b0;
      if (r < 4)        reset = 1'b1;
      else if (r < 20)  en = ~en;
      else if (r < 32)  mode = ~mode;
      else if (r < 80)  ch_mask = 4'($urandom);
      if (!en && r >= 900) en = 1'b1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
